// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: multi-channel write-side front end for the async FIFO write port.
// Every channel owns a small circular skid buffer. A round-robin arbiter drains
// the buffers into the FIFO write port, backs off while the FIFO is full, and
// stops forwarding once the FIFO reports an error.
// Optional build macro FIFO_WR_ARB_STATS_EN adds drop_cnt_o, a saturating
// per-channel count of dropped words.
//
// state | meaning
// RUN   | arbiter forwards buffered words whenever the FIFO is not full
// HALT  | FIFO reported an error; forwarding stopped, channels still buffer
module fifo_wr_arb #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int SKID_DEPTH = 4
) (
  input  logic                        wclk_i,
  input  logic                        rst_i,
  input  logic [CHANNELS-1:0]         ch_wr_en_i,
  input  logic [CHANNELS*WIDTH-1:0]   ch_wdata_i,
  output logic [CHANNELS-1:0]         ch_full_o,
  output logic [CHANNELS-1:0]         ch_error_o,
  output logic                        fifo_wr_en_o,
  output logic [WIDTH-1:0]            fifo_wdata_o,
  input  logic                        fifo_full_i,
  input  logic                        fifo_error_i,
  input  logic                        err_clr_i,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [CHANNELS*8-1:0]       drop_cnt_o,
`endif
  output logic [$clog2(CHANNELS)-1:0] grant_o,
  output logic                        halt_o
);

  localparam int GW = $clog2(CHANNELS);
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  mem    [CHANNELS][SKID_DEPTH];
  logic [PW-1:0]     wr_ptr [CHANNELS];
  logic [PW-1:0]     rd_ptr [CHANNELS];
  logic [CW-1:0]     cnt    [CHANNELS];
  logic [GW-1:0]     rr_ptr;

  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] drop;
  logic [GW-1:0]       sel;
  logic                any_nonempty;
  int                  idx;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full flags decoded straight from the registered occupancy counts.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++)
      ch_full_o[k] = (cnt[k] == CW'(SKID_DEPTH));
  end

  // Round-robin pick: first non-empty channel after the last one granted.
  always_comb begin
    sel          = '0;
    any_nonempty = 1'b0;
    idx          = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(rr_ptr) + i) % CHANNELS;
      if (!any_nonempty && (cnt[idx] != '0)) begin
        any_nonempty = 1'b1;
        sel          = GW'(idx);
      end
    end
  end

  // FIFO port; fifo_full_i gates the strobe combinationally so no write lands on a full FIFO.
  always_comb begin
    fifo_wr_en_o = (state == RUN) && any_nonempty && !fifo_full_i;
    fifo_wdata_o = any_nonempty ? mem[sel][rd_ptr[sel]] : '0;
    grant_o      = sel;
    halt_o       = (state == HALT);
  end

  // Per-channel push/pop/drop strobes; a full buffer drops even if it pops on the same edge.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      push[k] = ch_wr_en_i[k] && !ch_full_o[k];
      drop[k] = ch_wr_en_i[k] &&  ch_full_o[k];
      pop[k]  = fifo_wr_en_o && (sel == GW'(k));
    end
  end

  // Buffer storage; contents need no reset because the counts gate visibility.
  always_ff @(posedge wclk_i) begin
    for (int k = 0; k < CHANNELS; k++)
      if (push[k])
        mem[k][wr_ptr[k]] <= ch_wdata_i[k*WIDTH +: WIDTH];
  end

  // Buffer pointers, occupancy counts and sticky overflow flags (set beats clear).
  always_ff @(posedge wclk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
      ch_error_o <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (push[k])
          wr_ptr[k] <= ptr_next(wr_ptr[k]);
        if (pop[k])
          rd_ptr[k] <= ptr_next(rd_ptr[k]);
        if (push[k] && !pop[k])
          cnt[k] <= cnt[k] + 1'b1;
        else if (pop[k] && !push[k])
          cnt[k] <= cnt[k] - 1'b1;
      end
      ch_error_o <= drop | (ch_error_o & ~{CHANNELS{err_clr_i}});
    end
  end

  // Arbiter FSM and round-robin pointer.
  always_ff @(posedge wclk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= RUN;
      rr_ptr <= GW'(CHANNELS - 1);
    end else begin
      if (fifo_wr_en_o)
        rr_ptr <= sel;
      case (state)
        RUN:     if (fifo_error_i) state <= HALT;
        HALT:    if (err_clr_i && !fifo_error_i) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [7:0] drop_cnt [CHANNELS];

  // Saturating drop counters; a drop on the clearing edge leaves a count of one.
  always_ff @(posedge wclk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < CHANNELS; k++)
        drop_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (err_clr_i)
          drop_cnt[k] <= {7'd0, drop[k]};
        else if (drop[k] && (drop_cnt[k] != 8'hFF))
          drop_cnt[k] <= drop_cnt[k] + 8'd1;
      end
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    drop_cnt_o = '0;
    for (int k = 0; k < CHANNELS; k++)
      drop_cnt_o[k*8 +: 8] = drop_cnt[k];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb (default parameters, 4 channels of 8 bits).
module tb_fifo_wr_arb;

  logic        wclk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  ch_wr_en_i;
  logic [31:0] ch_wdata_i;
  logic [3:0]  ch_full_o;
  logic [3:0]  ch_error_o;
  logic        fifo_wr_en_o;
  logic [7:0]  fifo_wdata_o;
  logic        fifo_full_i;
  logic        fifo_error_i;
  logic        err_clr_i;
  logic [1:0]  grant_o;
  logic        halt_o;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [31:0] drop_cnt_o;
`endif

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [1:0] g;
    logic [7:0] d;
  } exp_t;
  exp_t exp_q[$];

  fifo_wr_arb #(.WIDTH(8), .CHANNELS(4), .SKID_DEPTH(4)) dut (
    .wclk_i       (wclk_i),
    .rst_i        (rst_i),
    .ch_wr_en_i   (ch_wr_en_i),
    .ch_wdata_i   (ch_wdata_i),
    .ch_full_o    (ch_full_o),
    .ch_error_o   (ch_error_o),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_error_i (fifo_error_i),
    .err_clr_i    (err_clr_i),
`ifdef FIFO_WR_ARB_STATS_EN
    .drop_cnt_o   (drop_cnt_o),
`endif
    .grant_o      (grant_o),
    .halt_o       (halt_o)
  );

  always #5 wclk_i = ~wclk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge wclk_i);
    #1;
  endtask

  task automatic expect_word(input logic [1:0] g, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    repeat (2) @(posedge wclk_i);
    #1 rst_i = 1'b1;
  endtask

  task automatic drain_wait();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: every write strobe seen at the falling edge must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk_i);
      if (rst_i === 1'b1 && fifo_wr_en_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write: grant=%0d data=%h expected no write at %0t",
                   grant_o, fifo_wdata_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("fifo_wdata", {24'd0, fifo_wdata_o}, {24'd0, e.d});
          check("grant", {30'd0, grant_o}, {30'd0, e.g});
        end
      end
    end
  end

  initial begin
    ch_wr_en_i   = '0;
    ch_wdata_i   = '0;
    fifo_full_i  = 1'b0;
    fifo_error_i = 1'b0;
    err_clr_i    = 1'b0;
    rst_i        = 1'b0;
    #2;
    check("reset_wr_en", {31'd0, fifo_wr_en_o}, 0);
    check("reset_wdata", {24'd0, fifo_wdata_o}, 0);
    check("reset_grant", {30'd0, grant_o}, 0);
    check("reset_full", {28'd0, ch_full_o}, 0);
    check("reset_error", {28'd0, ch_error_o}, 0);
    check("reset_halt", {31'd0, halt_o}, 0);
    do_reset();

    // Single word on channel 2.
    ch_wr_en_i = 4'b0100;
    ch_wdata_i = 32'h00A1_0000;
    expect_word(2'd2, 8'hA1);
    tick();
    ch_wr_en_i = '0;
    ch_wdata_i = '0;
    tick();
    @(negedge wclk_i);
    check("t1_idle_after", {31'd0, fifo_wr_en_o}, 0);
    drain_wait();

    // Two words on every channel, then a full-rate rotation.
    do_reset();
    fifo_full_i = 1'b1;
    ch_wr_en_i  = 4'hF;
    ch_wdata_i  = 32'h3020_1000;
    tick();
    ch_wdata_i  = 32'h3121_1101;
    tick();
    ch_wr_en_i  = '0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++)
        expect_word(2'(k), 8'((k << 4) | r));
    @(negedge wclk_i);
    check("t2_gated_by_full", {31'd0, fifo_wr_en_o}, 0);
    tick();
    fifo_full_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge wclk_i);
      check("t2_back_to_back", {31'd0, fifo_wr_en_o}, 1);
    end
    @(negedge wclk_i);
    check("t2_idle_after", {31'd0, fifo_wr_en_o}, 0);
    drain_wait();

    // Overflow on channel 0 while the FIFO is full.
    do_reset();
    fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ch_wr_en_i = 4'b0001;
      ch_wdata_i = 32'(8'h50 + i);
      tick();
    end
    for (int i = 0; i < 4; i++)
      expect_word(2'd0, 8'(8'h50 + i));
    check("t3_ch_full", {28'd0, ch_full_o}, 32'h1);
    check("t3_error_set", {28'd0, ch_error_o}, 32'h1);
    ch_wdata_i = 32'h55;
    err_clr_i  = 1'b1;
    tick();
    err_clr_i  = 1'b0;
    ch_wr_en_i = '0;
    check("t3_set_beats_clear", {28'd0, ch_error_o}, 32'h1);
`ifdef FIFO_WR_ARB_STATS_EN
    check("t3_drop_cnt_one", drop_cnt_o, 32'h1);
`endif
    fifo_full_i = 1'b0;
    drain_wait();
    check("t3_full_cleared", {28'd0, ch_full_o}, 0);
    check("t3_error_held", {28'd0, ch_error_o}, 32'h1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("t3_error_cleared", {28'd0, ch_error_o}, 0);
`ifdef FIFO_WR_ARB_STATS_EN
    check("t3_drop_cnt_cleared", drop_cnt_o, 0);
`endif

    // FIFO error during streaming, then recovery.
    do_reset();
    fifo_full_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ch_wr_en_i = 4'b1010;
      ch_wdata_i = {8'(8'h70 + i), 8'h00, 8'(8'h60 + i), 8'h00};
      tick();
    end
    ch_wr_en_i = '0;
    for (int i = 0; i < 4; i++) begin
      expect_word(2'd1, 8'(8'h60 + i));
      expect_word(2'd3, 8'(8'h70 + i));
    end
    fifo_full_i = 1'b0;
    tick();
    tick();
    fifo_error_i = 1'b1;
    tick();
    fifo_error_i = 1'b0;
    check("t4_halt", {31'd0, halt_o}, 1);
    @(negedge wclk_i);
    check("t4_halt_no_write", {31'd0, fifo_wr_en_o}, 0);
    tick();
    tick();
    @(negedge wclk_i);
    check("t4_halt_still_stopped", {31'd0, fifo_wr_en_o}, 0);
    check("t4_words_pending", exp_q.size(), 5);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("t4_run_again", {31'd0, halt_o}, 0);
    drain_wait();

    // Asynchronous reset mid-stream.
    do_reset();
    fifo_full_i = 1'b1;
    ch_wr_en_i  = 4'hF;
    ch_wdata_i  = 32'h8382_8180;
    tick();
    ch_wdata_i  = 32'h9392_9190;
    tick();
    ch_wr_en_i  = '0;
    expect_word(2'd0, 8'h80);
    expect_word(2'd1, 8'h81);
    fifo_full_i = 1'b0;
    tick();
    tick();
    check("t5_consumed_before_reset", exp_q.size(), 0);
    #2 rst_i = 1'b0;
    #1;
    check("t5_rst_wr_en", {31'd0, fifo_wr_en_o}, 0);
    check("t5_rst_wdata", {24'd0, fifo_wdata_o}, 0);
    check("t5_rst_grant", {30'd0, grant_o}, 0);
    check("t5_rst_full", {28'd0, ch_full_o}, 0);
    check("t5_rst_halt", {31'd0, halt_o}, 0);
    @(posedge wclk_i);
    #1 rst_i = 1'b1;
    ch_wr_en_i = 4'b0101;
    ch_wdata_i = 32'h00C2_00C0;
    expect_word(2'd0, 8'hC0);
    expect_word(2'd2, 8'hC2);
    tick();
    ch_wr_en_i = '0;
    drain_wait();

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
